// File: rtl/seg_display_pkg.sv
// Shared constants for the two-digit display driver: converter state codes,
// segment patterns (active-low {g,f,e,d,c,b,a}) and the digit decode helper.
package seg_display_pkg;

  localparam int VAL_W        = 6;
  localparam int SHIFT_CYCLES = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Value/mode in, digit enables/segments/busy out; clock and reset stay outside.
interface seg_display_driver_if;
  import seg_display_pkg::*;

  logic [VAL_W-1:0] val;
  logic             mode;
  logic [1:0]       an;
  logic [6:0]       seg;
  logic             busy;

  modport master (output val, output mode, input an, input seg, input busy);
  modport slave  (input val, input mode, output an, output seg, output busy);

endinterface

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with a one-cycle commit strobe.
//   state  | meaning
//   IDLE   | watching val against last_val
//   SHIFT  | six adjust-and-shift steps on the scratch
//   COMMIT | scratch final, done high for one cycle
module bin2bcd_seq
  import seg_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] val,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  logic [1:0]       state_q, state_d;
  logic [VAL_W-1:0] last_val_q, last_val_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  bcd_t             bcd_q, bcd_d, bcd_adj;
  logic [2:0]       cnt_q, cnt_d;

  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q.tens >= 4'd5) bcd_adj.tens = bcd_q.tens + 4'd3;
    if (bcd_q.ones >= 4'd5) bcd_adj.ones = bcd_q.ones + 4'd3;
  end

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (val != last_val_q) begin
          last_val_d = val;
          bin_d      = val;
          bcd_d      = '0;
          cnt_d      = 3'(SHIFT_CYCLES - 1);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        if (cnt_q == 3'd0) state_d = ST_COMMIT;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_val_q <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_COMMIT);
  assign tens = bcd_q.tens;
  assign ones = bcd_q.ones;

endmodule

// File: rtl/seg_display_driver.sv
// Two-digit common-anode display driver: BCD conversion, digit scan, leading-zero blank.
// Optional edit-mode blinking is built only when SEG_BLINK_EN is defined.
module seg_display_driver
  import seg_display_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter bit          LZ_BLANK    = 1'b1,
  parameter logic [23:0] BLINK_DIV   = 24'd5000000
) (
  input  logic                clk,
  input  logic                rst,
  seg_display_driver_if.slave sd
);

  logic       cv_busy, cv_done;
  logic [3:0] cv_tens, cv_ones;

  bin2bcd_seq u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .val  (sd.val),
    .busy (cv_busy),
    .done (cv_done),
    .tens (cv_tens),
    .ones (cv_ones)
  );

  bcd_t        digit_q, digit_d;
  logic [15:0] presc_q, presc_d;
  logic        sel_q, sel_d;
  logic [1:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        tc;
  logic        blank_force;

`ifdef SEG_BLINK_EN
  logic [23:0] blink_cnt_q;
  logic        blink_on_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_DIV - 24'd1) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 24'd1;
    end
  end

  assign blank_force = !sd.mode && !blink_on_q;
`else
  logic unused_mode;
  assign unused_mode = sd.mode;
  assign blank_force = 1'b0;
`endif

  // Decode from the next digit value so a commit reaches the pins one cycle later.
  always_comb begin
    digit_d = digit_q;
    if (cv_done) digit_d = {cv_tens, cv_ones};
  end

  always_comb begin
    tc      = (presc_q == REFRESH_DIV - 16'd1);
    presc_d = tc ? 16'd0 : presc_q + 16'd1;
    sel_d   = tc ? ~sel_q : sel_q;
    an_d    = 2'b11;
    seg_d   = SEG_BLANK;
    if (!blank_force) begin
      if (!sel_q) begin
        an_d  = 2'b10;
        seg_d = seg_decode(digit_d.ones);
      end else if (!(LZ_BLANK && (digit_d.tens == 4'd0))) begin
        an_d  = 2'b01;
        seg_d = seg_decode(digit_d.tens);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit_q <= '0;
      presc_q <= '0;
      sel_q   <= 1'b0;
      an_q    <= 2'b11;
      seg_q   <= SEG_BLANK;
    end else begin
      digit_q <= digit_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign sd.an   = an_q;
  assign sd.seg  = seg_q;
  assign sd.busy = cv_busy;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: two instances (leading-zero blank on/off), directed
// vector table, hand-written timing sequences and a random run against a cycle model.
`timescale 1ns/1ps
module tb_seg_display_driver;

  localparam int R = 4;
  localparam int B = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_display_driver_if if_a ();
  seg_display_driver_if if_b ();

  seg_display_driver #(.REFRESH_DIV(16'(R)), .LZ_BLANK(1'b1), .BLINK_DIV(24'(B))) dut_a (
    .clk(clk), .rst(rst), .sd(if_a));
  seg_display_driver #(.REFRESH_DIV(16'(R)), .LZ_BLANK(1'b0), .BLINK_DIV(24'(B))) dut_b (
    .clk(clk), .rst(rst), .sd(if_b));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [5:0] v, input logic m);
    if_a.val  = v;
    if_b.val  = v;
    if_a.mode = m;
    if_b.mode = m;
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Cycle model: e = edges since reset release; a conversion occupies 7 edges and
  // its value is on the pins right after the 7th; slots change every R edges.
  int         e, busy_left, last_v, pend_v, shown_v;
  bit         m_valid = 1'b0;
  bit         blank;
  logic [1:0] ea_an, eb_an;
  logic [6:0] ea_seg, eb_seg;
  logic       e_busy;

  always @(posedge clk) begin
    if (!rst) begin
      e = 0; busy_left = 0; last_v = 0; pend_v = 0; shown_v = 0;
      ea_an = 2'b11; eb_an = 2'b11; ea_seg = 7'h7F; eb_seg = 7'h7F; e_busy = 1'b0;
      m_valid = 1'b1;
    end else begin
      e++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) shown_v = pend_v;
      end else if (int'(if_a.val) != last_v) begin
        last_v    = int'(if_a.val);
        pend_v    = last_v;
        busy_left = 7;
      end
      e_busy = (busy_left > 0);
      blank  = 1'b0;
`ifdef SEG_BLINK_EN
      blank = (if_a.mode == 1'b0) && ((((e - 1) / B) % 2) == 1);
`endif
      if (blank) begin
        ea_an = 2'b11; ea_seg = 7'h7F; eb_an = 2'b11; eb_seg = 7'h7F;
      end else if ((((e - 1) / R) % 2) == 0) begin
        ea_an = 2'b10; ea_seg = seg_of(shown_v % 10);
        eb_an = 2'b10; eb_seg = seg_of(shown_v % 10);
      end else begin
        eb_an = 2'b01; eb_seg = seg_of(shown_v / 10);
        if (shown_v / 10 == 0) begin ea_an = 2'b11; ea_seg = 7'h7F; end
        else begin ea_an = 2'b01; ea_seg = seg_of(shown_v / 10); end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_a", 32'({if_a.an, if_a.seg, if_a.busy}), 32'({ea_an, ea_seg, e_busy}));
      chk("model_b", 32'({if_b.an, if_b.seg, if_b.busy}), 32'({eb_an, eb_seg, e_busy}));
    end
  end

  // One full scan period with blinking off: every slot must show the expected digit.
  task automatic check_window(input string name, input logic [6:0] t, input logic [6:0] o,
                              input bit tb);
    int n_ones;
    logic [8:0] exp_a_tens;
    n_ones     = 0;
    exp_a_tens = tb ? {2'b11, 7'h7F} : {2'b01, t};
    for (int k = 0; k < 2 * R; k++) begin
      @(negedge clk);
      if (if_b.an == 2'b10) begin
        n_ones++;
        chk({name, "_b_ones"}, 32'(if_b.seg), 32'(o));
      end else begin
        chk({name, "_b_tens"}, 32'({if_b.an, if_b.seg}), 32'({2'b01, (tb ? 7'h40 : t)}));
      end
      if (if_a.an == 2'b10) chk({name, "_a_ones"}, 32'(if_a.seg), 32'(o));
      else chk({name, "_a_tens"}, 32'({if_a.an, if_a.seg}), 32'(exp_a_tens));
    end
    chk({name, "_slots"}, 32'(n_ones), 32'(R));
  endtask

  typedef struct {
    logic [5:0] v;
    logic [6:0] t;
    logic [6:0] o;
    bit         tz;
  } vec_t;

  vec_t tbl [10];
  int   busy_n, blank_n;

  initial begin
    tbl[0] = '{6'd45, 7'h19, 7'h12, 1'b0};
    tbl[1] = '{6'd59, 7'h12, 7'h10, 1'b0};
    tbl[2] = '{6'd63, 7'h02, 7'h30, 1'b0};
    tbl[3] = '{6'd9,  7'h40, 7'h10, 1'b1};
    tbl[4] = '{6'd10, 7'h79, 7'h40, 1'b0};
    tbl[5] = '{6'd37, 7'h30, 7'h78, 1'b0};
    tbl[6] = '{6'd60, 7'h02, 7'h40, 1'b0};
    tbl[7] = '{6'd7,  7'h40, 7'h78, 1'b1};
    tbl[8] = '{6'd0,  7'h40, 7'h40, 1'b1};
    tbl[9] = '{6'd28, 7'h24, 7'h00, 1'b0};

    rst = 1'b0;
    set_in(6'd0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_an",   32'(if_a.an),   32'(2'b11));
      chk("rst_seg",  32'(if_a.seg),  32'(7'h7F));
      chk("rst_busy", 32'(if_a.busy), 32'(1'b0));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ones", 32'({if_a.an, if_a.seg}), 32'({2'b10, 7'h40}));
    repeat (R) @(negedge clk);
    chk("rel_tens_blank", 32'({if_a.an, if_a.seg}), 32'({2'b11, 7'h7F}));
    chk("rel_tens_lz0",   32'({if_b.an, if_b.seg}), 32'({2'b01, 7'h40}));

    // Busy spans exactly seven cycles after the capture edge.
    set_in(6'd45, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("busy_%0d", k), 32'(if_a.busy), 32'(k <= 7));
    end
    check_window("v45", 7'h19, 7'h12, 1'b0);

    foreach (tbl[i]) begin
      set_in(tbl[i].v, 1'b1);
      repeat (12) @(negedge clk);
      check_window($sformatf("tbl%0d", i), tbl[i].t, tbl[i].o, tbl[i].tz);
    end

    // New value arriving mid-conversion: first result commits, then a second pass.
    set_in(6'd12, 1'b1);
    busy_n = 0;
    repeat (3) begin @(negedge clk); busy_n += int'(if_a.busy); end
    set_in(6'd37, 1'b1);
    repeat (20) begin @(negedge clk); busy_n += int'(if_a.busy); end
    chk("late_busy_cycles", 32'(busy_n), 32'd14);
    check_window("late37", 7'h30, 7'h78, 1'b0);

    // Reset in the middle of a conversion.
    set_in(6'd63, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst", 32'({if_a.an, if_a.seg, if_a.busy}), 32'({2'b11, 7'h7F, 1'b0}));
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check_window("post_rst63", 7'h02, 7'h30, 1'b0);

    // Blinking: edit mode blanks half of every 2*B cycles only when built in.
    set_in(6'd45, 1'b0);
    blank_n = 0;
    repeat (4 * B) begin @(negedge clk); blank_n += int'(if_b.an == 2'b11); end
`ifdef SEG_BLINK_EN
    chk("blink_mode0", 32'(blank_n), 32'(2 * B));
`else
    chk("blink_mode0", 32'(blank_n), 32'd0);
`endif
    set_in(6'd45, 1'b1);
    blank_n = 0;
    repeat (4 * B) begin @(negedge clk); blank_n += int'(if_b.an == 2'b11); end
    chk("blink_mode1", 32'(blank_n), 32'd0);

    for (int it = 0; it < 250; it++) begin
      set_in(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 15)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
